palette_lut: RTL and testbench
==============================

PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 SHALL have parameter IDX_W, default 5: pixel/palette index width; N = 2**IDX_W entries.
REQ-002 SHALL have parameter CH_W, default 8: width of each colour channel.
REQ-003 SHALL have parameter STEP, default 8: fade-level change per frame_start pulse, range 1..256.
REQ-004 SHALL have port Clk  in  1: single clock; all state on rising edge.
REQ-005 SHALL have port Reset_n  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port wr_en  in  1: palette write strobe.
REQ-007 SHALL have port wr_addr  in  IDX_W: palette entry to write.
REQ-008 SHALL have port wr_data  in  3*CH_W: {R,G,B} for that entry.
REQ-009 SHALL have port pix_valid  in  1: lookup request this cycle.
REQ-010 SHALL have port pix_idx  in  IDX_W: palette index; 0 means transparent.
REQ-011 SHALL have port DrawX  in  10: current pixel column.
REQ-012 SHALL have port frame_start  in  1: one-cycle pulse per frame.
REQ-013 SHALL have port fade_target  in  9: requested brightness, 0..256.
REQ-014 SHALL have port VGA_R, VGA_G, VGA_B  out  CH_W each: registered pixel colour.
REQ-015 SHALL have port out_valid  out  1: VGA_* hold a lookup result.
REQ-016 SHALL have port fade_busy  out  1: brightness level not equal to target.

Function
REQ-017 SHALL hold N x 3*CH_W palette entries in registers; a write with wr_en=1 updates wr_addr at the clock edge.
REQ-018 SHALL give a fixed latency of 2 cycles: request at edge k gives VGA_* and out_valid=1 after edge k+2. Back-to-back requests give one result per cycle.
REQ-019 SHALL clear out_valid 2 cycles after a cycle with pix_valid=0; VGA_* then hold their last value.
REQ-020 SHALL, on a write and a lookup of the same index in the same cycle, return the newly written data (write bypass).
REQ-021 SHALL, for pix_idx=0, ignore entry 0 and output the background colour.
REQ-022 Background colour SHALL be R = 0x67 and G = 0xD8 (zero-extended or MSB-truncated to CH_W), with B = all-ones(CH_W) - {1'b0, DrawX[9:3]} truncated to CH_W.
REQ-023 SHALL register DrawX alongside pix_idx in stage 1.
REQ-024 SHALL scale each channel in stage 2 as out = (c * level) >> 8, with level a 9-bit register.
REQ-025 The product in REQ-024 SHALL be CH_W+9 bits, with no rounding.
REQ-026 SHALL give exact identity at level = 256 and 0 at level = 0.
REQ-027 SHALL treat fade_target > 256 as 256 (clamp).
REQ-028 Fade state machine SHALL have states IDLE, UP and DOWN.
REQ-029 In IDLE, SHALL go to UP when clamped target > level and to DOWN when clamped target < level.
REQ-030 SHALL change level only on a frame_start pulse while in UP or DOWN.
REQ-031 In UP, each frame_start SHALL set level = min(level+STEP, target); in DOWN, level = max(level-STEP, target).
REQ-032 SHALL return to IDLE when level equals target.
REQ-033 SHALL re-evaluate direction each frame_start if fade_target changes mid-fade; a reversal is taken immediately and overshoot is never allowed.
REQ-034 fade_busy SHALL equal (state != IDLE), registered.
REQ-035 Level SHALL be constant within a frame, so every pixel of a frame uses one level.

Reset
REQ-036 SHALL, while Reset_n=0 (asynchronous, regardless of Clk), force all palette entries to 0, VGA_R/G/B = 0, out_valid = 0, level = 256, state = IDLE, fade_busy = 0, and pipeline valids to 0.
REQ-037 SHALL discard any in-flight lookup when Reset_n asserts mid-pipeline; nothing is emitted after release.
REQ-038 SHALL accept the first write or lookup on the first edge after Reset_n rises.

Verification
REQ-039 Bench SHALL check: reset, write idx 5 = 0x87A8D0, lookup idx 5 at edge k -> VGA = 87/A8/D0 and out_valid=1 after edge k+2; out_valid=0 at k+1.
REQ-040 Bench SHALL check: same-cycle write idx 3 = 0x0F4CE9 and lookup idx 3 -> 0F/4C/E9 (bypass), not the old value 0.
REQ-041 Bench SHALL check: pix_idx=0, DrawX=80 -> 67/D8/F5; DrawX=639 -> B = 0xFF - 0x4F = 0xB0.
REQ-042 Bench SHALL check: fade_target=0, STEP=8, level 256 -> fade_busy=1 and 32 frame_start pulses to reach level 0; entry 0xFFFDFD gives 7F/7E/7E at level 128 and 00/00/00 at level 0; fade_busy=0 after.
REQ-043 Bench SHALL check: during DOWN at level 100, fade_target changes to 104 -> next frame_start gives level 104 (clamped, no overshoot) and IDLE.
REQ-044 Bench SHALL check: Reset_n pulsed low between Clk edges with 2 lookups in flight -> outputs 0 immediately, no out_valid after release, and palette reads back 0.

Source files
------------

// File: rtl/palette_lut.sv
// Palette lookup with a two-stage pipeline: stage 1 captures the entry (with write
// bypass) or background request, stage 2 applies a frame-synchronous fade level.
module palette_lut #(
    parameter int IDX_W = 5,
    parameter int CH_W  = 8,
    parameter int STEP  = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                pix_valid,
    input  logic [IDX_W-1:0]    pix_idx,
    input  logic [9:0]          DrawX,
    input  logic                frame_start,
    input  logic [8:0]          fade_target,
    output logic [CH_W-1:0]     VGA_R,
    output logic [CH_W-1:0]     VGA_G,
    output logic [CH_W-1:0]     VGA_B,
    output logic                out_valid,
    output logic                fade_busy
);

    localparam int N     = 2 ** IDX_W;
    localparam int RGB_W = 3 * CH_W;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } fade_state_e;

    logic [RGB_W-1:0] pal_q [N];
    logic [RGB_W-1:0] pal_d [N];

    logic             s1_valid_q, s1_valid_d;
    logic             s1_transp_q, s1_transp_d;
    logic [RGB_W-1:0] s1_rgb_q, s1_rgb_d;
    logic [6:0]       s1_drawx_q, s1_drawx_d;

    logic [RGB_W-1:0] vga_q, vga_d;
    logic             out_valid_q, out_valid_d;

    fade_state_e      state_q, state_d;
    logic [8:0]       level_q, level_d;
    logic             fade_busy_q, fade_busy_d;

    logic [8:0]       tgt;
    logic [9:0]       up_sum;
    logic [9:0]       down_floor;
    logic [RGB_W-1:0] src_rgb;
    logic [RGB_W-1:0] scaled_rgb;

    // Palette storage and stage 1: a same-cycle write to the looked-up entry wins.
    always_comb begin
        pal_d = pal_q;
        if (wr_en) pal_d[wr_addr] = wr_data;

        s1_valid_d  = pix_valid;
        s1_transp_d = (pix_idx == '0);
        s1_rgb_d    = (wr_en && (wr_addr == pix_idx)) ? wr_data : pal_q[pix_idx];
        s1_drawx_d  = DrawX[9:3];
    end

    // Stage 2: background substitution, then per-channel (c * level) >> 8.
    always_comb begin
        src_rgb    = s1_rgb_q;
        scaled_rgb = '0;
        if (s1_transp_q) begin
            src_rgb = {CH_W'(8'h67), CH_W'(8'hD8),
                       {CH_W{1'b1}} - CH_W'({1'b0, s1_drawx_q})};
        end
        for (int unsigned ch = 0; ch < 3; ch++) begin
            scaled_rgb[ch*CH_W +: CH_W] =
                CH_W'(((CH_W+9)'(src_rgb[ch*CH_W +: CH_W]) * (CH_W+9)'(level_q)) >> 8);
        end
        vga_d       = s1_valid_q ? scaled_rgb : vga_q;
        out_valid_d = s1_valid_q;
    end

    // Fade FSM: level only moves on frame_start, so a whole frame sees one level.
    always_comb begin
        tgt        = (fade_target > 9'd256) ? 9'd256 : fade_target;
        up_sum     = {1'b0, level_q} + 10'(STEP);
        down_floor = {1'b0, tgt} + 10'(STEP);
        state_d    = state_q;
        level_d    = level_q;

        case (state_q)
            IDLE: begin
                if (tgt > level_q)      state_d = UP;
                else if (tgt < level_q) state_d = DOWN;
            end
            UP, DOWN: begin
                if (frame_start) begin
                    // Direction is recomputed from the live target, so a reversal never overshoots.
                    if (tgt > level_q) begin
                        level_d = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[8:0];
                    end else if (tgt < level_q) begin
                        level_d = ({1'b0, level_q} >= down_floor)
                                  ? 9'({1'b0, level_q} - 10'(STEP)) : tgt;
                    end
                    if (level_d == tgt)     state_d = IDLE;
                    else if (tgt > level_d) state_d = UP;
                    else                    state_d = DOWN;
                end else if (tgt == level_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        fade_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < N; i++) pal_q[i] <= '0;
            s1_valid_q  <= 1'b0;
            s1_transp_q <= 1'b0;
            s1_rgb_q    <= '0;
            s1_drawx_q  <= '0;
            vga_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            level_q     <= 9'd256;
            fade_busy_q <= 1'b0;
        end else begin
            pal_q       <= pal_d;
            s1_valid_q  <= s1_valid_d;
            s1_transp_q <= s1_transp_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_drawx_q  <= s1_drawx_d;
            vga_q       <= vga_d;
            out_valid_q <= out_valid_d;
            state_q     <= state_d;
            level_q     <= level_d;
            fade_busy_q <= fade_busy_d;
        end
    end

    assign VGA_R     = vga_q[RGB_W-1 -: CH_W];
    assign VGA_G     = vga_q[2*CH_W-1 -: CH_W];
    assign VGA_B     = vga_q[CH_W-1:0];
    assign out_valid = out_valid_q;
    assign fade_busy = fade_busy_q;

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: directed scenarios plus randomized
// lookups/writes checked against an arithmetic reference model.
module tb_palette_lut;

    localparam int IDX_W = 5;
    localparam int CH_W  = 8;
    localparam int STEP  = 8;

    logic              Clk;
    logic              Reset_n;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [23:0]       wr_data;
    logic              pix_valid;
    logic [IDX_W-1:0]  pix_idx;
    logic [9:0]        DrawX;
    logic              frame_start;
    logic [8:0]        fade_target;
    logic [CH_W-1:0]   VGA_R, VGA_G, VGA_B;
    logic              out_valid;
    logic              fade_busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [23:0] pal_m [32];
    int          level_m;

    palette_lut #(.IDX_W(IDX_W), .CH_W(CH_W), .STEP(STEP)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pix_valid(pix_valid), .pix_idx(pix_idx),
        .DrawX(DrawX), .frame_start(frame_start), .fade_target(fade_target),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .out_valid(out_valid), .fade_busy(fade_busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rgb_out();
        return {8'h00, VGA_R, VGA_G, VGA_B};
    endfunction

    // Reference: background colour and fade scaling from plain integer arithmetic.
    function automatic logic [23:0] bg_color(input int dx);
        int b;
        b = (255 - dx / 8) % 256;
        return {8'h67, 8'hD8, 8'(b)};
    endfunction

    function automatic logic [23:0] scale(input logic [23:0] c, input int lvl);
        int r, g, b;
        r = int'(c[23:16]) * lvl / 256;
        g = int'(c[15:8])  * lvl / 256;
        b = int'(c[7:0])   * lvl / 256;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        tick();
        wr_en      = 1'b0;
        pal_m[a]   = d;
    endtask

    task automatic lookup_check(input string tag, input int idx, input int dx, input logic [23:0] exp);
        pix_valid = 1'b1;
        pix_idx   = 5'(idx);
        DrawX     = 10'(dx);
        tick();
        pix_valid = 1'b0;
        check_eq({tag, "_ov_early"}, 32'(out_valid), 32'd0);
        tick();
        check_eq({tag, "_ov"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_rgb"}, rgb_out(), {8'h00, exp});
    endtask

    task automatic fade_pulse();
        int t;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        t = (fade_target > 256) ? 256 : int'(fade_target);
        if (t > level_m)      level_m = (level_m + STEP < t) ? level_m + STEP : t;
        else if (t < level_m) level_m = (level_m - STEP > t) ? level_m - STEP : t;
    endtask

    task automatic run_random(input string tag, input int n);
        logic        pend_v, cur_v;
        logic [23:0] pend_c, cur_c;
        pend_v = 1'b0;
        pend_c = '0;
        for (int i = 0; i < n; i++) begin
            wr_en     = ($urandom % 2) == 0;
            wr_addr   = 5'($urandom);
            wr_data   = 24'($urandom);
            pix_valid = ($urandom % 4) != 0;
            pix_idx   = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
            DrawX     = 10'($urandom_range(0, 1023));
            cur_v = pix_valid;
            cur_c = '0;
            if (pix_valid) begin
                if (pix_idx == 0)                     cur_c = bg_color(int'(DrawX));
                else if (wr_en && wr_addr == pix_idx) cur_c = wr_data;
                else                                  cur_c = pal_m[pix_idx];
                cur_c = scale(cur_c, level_m);
            end
            if (wr_en) pal_m[wr_addr] = wr_data;
            tick();
            check_eq({tag, "_ov"}, 32'(out_valid), 32'(pend_v));
            if (pend_v) check_eq({tag, "_rgb"}, rgb_out(), {8'h00, pend_c});
            pend_v = cur_v;
            pend_c = cur_c;
        end
        wr_en     = 1'b0;
        pix_valid = 1'b0;
        tick();
        check_eq({tag, "_ov_last"}, 32'(out_valid), 32'(pend_v));
        if (pend_v) check_eq({tag, "_rgb_last"}, rgb_out(), {8'h00, pend_c});
    endtask

    initial begin
        int cnt;
        Reset_n     = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        pix_valid   = 1'b0;
        pix_idx     = '0;
        DrawX       = '0;
        frame_start = 1'b0;
        fade_target = 9'd256;
        level_m     = 256;
        for (int i = 0; i < 32; i++) pal_m[i] = '0;

        #12;
        check_eq("rst_rgb", rgb_out(), 32'h0);
        check_eq("rst_ov", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(fade_busy), 32'd0);

        @(negedge Clk);
        Reset_n = 1'b1;
        write_entry(5, 24'h87A8D0);
        lookup_check("lut5", 5, 0, 24'h87A8D0);
        tick();
        check_eq("ov_clear", 32'(out_valid), 32'd0);
        check_eq("rgb_hold", rgb_out(), 32'h0087A8D0);

        // Same-cycle write and lookup of entry 3.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 24'h0F4CE9;
        pix_valid = 1'b1; pix_idx = 5'd3;
        tick();
        wr_en = 1'b0; pix_valid = 1'b0; pal_m[3] = 24'h0F4CE9;
        check_eq("byp_ov_early", 32'(out_valid), 32'd0);
        tick();
        check_eq("byp_rgb", rgb_out(), 32'h000F4CE9);
        check_eq("byp_ov", 32'(out_valid), 32'd1);

        lookup_check("bg80", 0, 80, 24'h67D8F5);
        lookup_check("bg639", 0, 639, 24'h67D8B0);

        run_random("rnd256", 200);

        // Fade down to 0, probing level 128 midway.
        write_entry(7, 24'hFFFDFD);
        fade_target = 9'd0;
        tick();
        check_eq("fade_busy_start", 32'(fade_busy), 32'd1);
        cnt = 0;
        for (int p = 0; p < 40; p++) begin
            if (!fade_busy) break;
            fade_pulse();
            cnt++;
            if (cnt == 16) begin
                lookup_check("lvl128", 7, 0, 24'h7F7E7E);
                run_random("rnd128", 100);
                write_entry(7, 24'hFFFDFD);
            end
        end
        check_eq("fade_pulses", 32'(cnt), 32'd32);
        check_eq("fade_busy_end", 32'(fade_busy), 32'd0);
        lookup_check("lvl0", 7, 0, 24'h000000);
        lookup_check("lvl0_bg", 0, 80, 24'h000000);

        // Up to 100, start down, then retarget 104 mid-fade.
        fade_target = 9'd100;
        tick();
        cnt = 0;
        for (int p = 0; p < 40; p++) begin
            if (!fade_busy) break;
            fade_pulse();
            cnt++;
        end
        check_eq("up100_pulses", 32'(cnt), 32'd13);
        check_eq("up100_model", 32'(level_m), 32'd100);
        fade_target = 9'd0;
        tick();
        check_eq("down_busy", 32'(fade_busy), 32'd1);
        fade_target = 9'd104;
        tick();
        check_eq("retarget_busy", 32'(fade_busy), 32'd1);
        fade_pulse();
        check_eq("retarget_idle", 32'(fade_busy), 32'd0);
        lookup_check("lvl104", 7, 0, 24'h676666);
        lookup_check("lvl104_model", 7, 0, scale(24'hFFFDFD, level_m));

        // Target above 256 clamps to full brightness.
        fade_target = 9'd300;
        tick();
        cnt = 0;
        for (int p = 0; p < 40; p++) begin
            if (!fade_busy) break;
            fade_pulse();
            cnt++;
        end
        check_eq("clamp_pulses", 32'(cnt), 32'd19);
        lookup_check("lvl256", 7, 0, 24'hFFFDFD);

        // Asynchronous reset with lookups in flight.
        write_entry(3, 24'h0F4CE9);
        write_entry(5, 24'h87A8D0);
        lookup_check("pre_rst", 5, 0, 24'h87A8D0);
        fade_target = 9'd0;
        pix_valid = 1'b1; pix_idx = 5'd5;
        tick();
        check_eq("pre_rst_busy", 32'(fade_busy), 32'd1);
        pix_idx = 5'd3;
        #2;
        Reset_n = 1'b0;
        #1;
        check_eq("arst_rgb", rgb_out(), 32'h0);
        check_eq("arst_ov", 32'(out_valid), 32'd0);
        check_eq("arst_busy", 32'(fade_busy), 32'd0);
        pix_valid   = 1'b0;
        fade_target = 9'd256;
        level_m     = 256;
        for (int i = 0; i < 32; i++) pal_m[i] = '0;
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_ov", 32'(out_valid), 32'd0);
        end
        lookup_check("post_rst5", 5, 0, pal_m[5]);
        lookup_check("post_rst3", 3, 0, 24'h000000);
        lookup_check("post_rst_bg", 0, 0, 24'h67D8FF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
